// File: rtl/lbuf_pkg.sv
// Shared types and width helpers for the line-buffer write address generator.
package lbuf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FULL
    } lbuf_wstate_e;

    function automatic int addr_width(input int pix, input int beat);
        int w;
        w = $clog2(pix / beat);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int bank_width(input int lines);
        return (lines <= 2) ? 1 : $clog2(lines);
    endfunction

endpackage

// File: rtl/edge_det.sv
// Registered rise/fall detector: keeps a one-cycle delayed copy of sig and
// compares it against the live input.
module edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    assign rise = sig & ~sig_d;
    assign fall = ~sig & sig_d;

endmodule

// File: rtl/lbuf_waddr_gen.sv
// Write-side address generator for a LINES-deep circular line buffer: turns
// sensor href/vsync/de timing into addr/bank/we and line-close reporting.
module lbuf_waddr_gen
    import lbuf_pkg::*;
#(
    parameter  int PIX_PER_LINE = 1280,
    parameter  int BEAT         = 1,
    parameter  int LINES        = 2,
    parameter  int MAX_LINES    = 720,
    localparam int ADDR_W       = addr_width(PIX_PER_LINE, BEAT),
    localparam int BANK_W       = bank_width(LINES),
    localparam int LCNT_W       = $clog2(MAX_LINES + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              vsync,
    input  logic              href,
    input  logic              de,
    output logic [ADDR_W-1:0] addr,
    output logic [BANK_W-1:0] bank,
    output logic              we,
    output logic              line_done,
    output logic [BANK_W-1:0] done_bank,
    output logic [LCNT_W-1:0] line_cnt,
    output logic              short_err,
    output logic              ovf_err
);

    localparam int BEATS = PIX_PER_LINE / BEAT;

    lbuf_wstate_e      state;
    logic [ADDR_W-1:0] cnt;
    logic              href_rise;
    logic              href_fall;
    logic              vsync_rise;
    logic              unused_vsync_fall;
    logic              last_beat;
    logic              close_line;
    logic [BANK_W-1:0] bank_next;

    edge_det u_href_edge (
        .clk  (clk),
        .rstn (rstn),
        .sig  (href),
        .rise (href_rise),
        .fall (href_fall)
    );

    edge_det u_vsync_edge (
        .clk  (clk),
        .rstn (rstn),
        .sig  (vsync),
        .rise (vsync_rise),
        .fall (unused_vsync_fall)
    );

    assign last_beat  = (cnt == ADDR_W'(BEATS - 1));
    // A frame restart abandons any open line, so it suppresses the close.
    assign close_line = ~vsync_rise & (state == ACTIVE) & ((de & last_beat) | href_fall);
    assign bank_next  = (bank == BANK_W'(LINES - 1)) ? '0 : bank + BANK_W'(1);

    assign we   = de & (state == ACTIVE);
    assign addr = cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            bank      <= '0;
            line_done <= 1'b0;
            done_bank <= '0;
            line_cnt  <= '0;
            short_err <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (vsync_rise) begin
                bank      <= '0;
                line_cnt  <= '0;
                short_err <= 1'b0;
                ovf_err   <= 1'b0;
                if (href_rise) begin
                    state <= ACTIVE;
                    cnt   <= '0;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (de) begin
                            ovf_err <= 1'b1;
                        end
                        if (href_rise) begin
                            state <= ACTIVE;
                            cnt   <= '0;
                        end
                    end
                    ACTIVE: begin
                        // The last beat wins over a coincident href fall: full close, no short flag.
                        if (de && last_beat) begin
                            state <= href_fall ? IDLE : FULL;
                        end else begin
                            if (de) begin
                                cnt <= cnt + ADDR_W'(1);
                            end
                            if (href_fall) begin
                                short_err <= 1'b1;
                                state     <= IDLE;
                            end
                        end
                    end
                    FULL: begin
                        if (de) begin
                            ovf_err <= 1'b1;
                        end
                        if (href_fall) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase

                if (close_line) begin
                    done_bank <= bank;
                    bank      <= bank_next;
                    line_done <= 1'b1;
                    if (line_cnt != LCNT_W'(MAX_LINES)) begin
                        line_cnt <= line_cnt + LCNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lbuf_waddr_gen.sv
// Drives two configurations of lbuf_waddr_gen with directed and random sensor
// timing and compares every output each cycle against a line/frame model.
module tb_lbuf_waddr_gen;

    logic clk;
    logic rstn;
    logic vsync;
    logic href;
    logic de;

    logic [10:0] a_addr;
    logic [0:0]  a_bank;
    logic        a_we;
    logic        a_line_done;
    logic [0:0]  a_done_bank;
    logic [9:0]  a_line_cnt;
    logic        a_short_err;
    logic        a_ovf_err;

    logic [3:0]  b_addr;
    logic [1:0]  b_bank;
    logic        b_we;
    logic        b_line_done;
    logic [1:0]  b_done_bank;
    logic [2:0]  b_line_cnt;
    logic        b_short_err;
    logic        b_ovf_err;

    int checks = 0;
    int errors = 0;

    lbuf_waddr_gen u_dut_a (
        .clk       (clk),
        .rstn      (rstn),
        .vsync     (vsync),
        .href      (href),
        .de        (de),
        .addr      (a_addr),
        .bank      (a_bank),
        .we        (a_we),
        .line_done (a_line_done),
        .done_bank (a_done_bank),
        .line_cnt  (a_line_cnt),
        .short_err (a_short_err),
        .ovf_err   (a_ovf_err)
    );

    lbuf_waddr_gen #(
        .PIX_PER_LINE (64),
        .BEAT         (4),
        .LINES        (3),
        .MAX_LINES    (5)
    ) u_dut_b (
        .clk       (clk),
        .rstn      (rstn),
        .vsync     (vsync),
        .href      (href),
        .de        (de),
        .addr      (b_addr),
        .bank      (b_bank),
        .we        (b_we),
        .line_done (b_line_done),
        .done_bank (b_done_bank),
        .line_cnt  (b_line_cnt),
        .short_err (b_short_err),
        .ovf_err   (b_ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference view of a frame: a line is open or not, filled or not, and the
    // bank is simply the number of lines closed this frame modulo LINES.
    typedef struct {
        bit open;
        bit full;
        int pos;
        int closes;
        int done_bank;
        bit ldone;
        bit short_e;
        bit ovf_e;
        bit href_prev;
        bit vsync_prev;
    } model_t;

    model_t m[2];

    function automatic int beatsOf(input int k);
        return (k == 0) ? 1280 : 16;
    endfunction

    function automatic int linesOf(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int maxOf(input int k);
        return (k == 0) ? 720 : 5;
    endfunction

    function automatic void modelReset(input int k);
        m[k] = '{default: 0};
    endfunction

    function automatic void modelStep(input int k, input bit v, input bit h, input bit d);
        model_t n;
        bit v_rise, h_rise, h_fall, closing;
        n       = m[k];
        n.ldone = 1'b0;
        closing = 1'b0;
        v_rise  = v & ~m[k].vsync_prev;
        h_rise  = h & ~m[k].href_prev;
        h_fall  = ~h & m[k].href_prev;
        if (v_rise) begin
            n.closes  = 0;
            n.short_e = 1'b0;
            n.ovf_e   = 1'b0;
            n.open    = h_rise;
            n.full    = 1'b0;
            if (h_rise) n.pos = 0;
        end else if (!m[k].open) begin
            if (d) n.ovf_e = 1'b1;
            if (h_rise) begin
                n.open = 1'b1;
                n.full = 1'b0;
                n.pos  = 0;
            end
        end else if (!m[k].full) begin
            if (d && m[k].pos == beatsOf(k) - 1) begin
                closing = 1'b1;
                if (h_fall) n.open = 1'b0;
                else n.full = 1'b1;
            end else begin
                if (d) n.pos = m[k].pos + 1;
                if (h_fall) begin
                    closing   = 1'b1;
                    n.short_e = 1'b1;
                    n.open    = 1'b0;
                end
            end
        end else begin
            if (d) n.ovf_e = 1'b1;
            if (h_fall) begin
                n.open = 1'b0;
                n.full = 1'b0;
            end
        end
        if (closing) begin
            n.done_bank = m[k].closes % linesOf(k);
            n.closes    = m[k].closes + 1;
            n.ldone     = 1'b1;
        end
        n.href_prev  = h;
        n.vsync_prev = v;
        m[k]         = n;
    endfunction

    function automatic int expBank(input int k);
        return m[k].closes % linesOf(k);
    endfunction

    function automatic int expLineCnt(input int k);
        return (m[k].closes > maxOf(k)) ? maxOf(k) : m[k].closes;
    endfunction

    function automatic int expWe(input int k);
        return (de && m[k].open && !m[k].full) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: observed %0d expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic compareAll();
        checkOutput("a_addr",      32'(a_addr),      32'(m[0].pos));
        checkOutput("a_bank",      32'(a_bank),      32'(expBank(0)));
        checkOutput("a_we",        32'(a_we),        32'(expWe(0)));
        checkOutput("a_line_done", 32'(a_line_done), 32'(m[0].ldone));
        checkOutput("a_done_bank", 32'(a_done_bank), 32'(m[0].done_bank));
        checkOutput("a_line_cnt",  32'(a_line_cnt),  32'(expLineCnt(0)));
        checkOutput("a_short_err", 32'(a_short_err), 32'(m[0].short_e));
        checkOutput("a_ovf_err",   32'(a_ovf_err),   32'(m[0].ovf_e));
        checkOutput("b_addr",      32'(b_addr),      32'(m[1].pos));
        checkOutput("b_bank",      32'(b_bank),      32'(expBank(1)));
        checkOutput("b_we",        32'(b_we),        32'(expWe(1)));
        checkOutput("b_line_done", 32'(b_line_done), 32'(m[1].ldone));
        checkOutput("b_done_bank", 32'(b_done_bank), 32'(m[1].done_bank));
        checkOutput("b_line_cnt",  32'(b_line_cnt),  32'(expLineCnt(1)));
        checkOutput("b_short_err", 32'(b_short_err), 32'(m[1].short_e));
        checkOutput("b_ovf_err",   32'(b_ovf_err),   32'(m[1].ovf_e));
    endtask

    // One clock: drive inputs just after the rising edge, check on the falling
    // edge, advance the model on the next rising edge.
    task automatic applyStimulus(input bit v, input bit h, input bit d);
        vsync = v;
        href  = h;
        de    = d;
        @(negedge clk);
        compareAll();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rstn) modelReset(k);
            else modelStep(k, v, h, d);
        end
        #1;
    endtask

    task automatic runLine(input int n_de);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (n_de) applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic frameStart();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rstn  = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        de    = 1'b0;
        modelReset(0);
        modelReset(1);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        rstn = 1'b1;

        // Full 1280-beat line on the default configuration.
        runLine(1280);
        checkOutput("full_line_bank",      32'(a_bank),      32'd1);
        checkOutput("full_line_done_bank", 32'(a_done_bank), 32'd0);
        checkOutput("full_line_cnt",       32'(a_line_cnt),  32'd1);
        checkOutput("full_line_short",     32'(a_short_err), 32'd0);

        // Five full lines then one more on the packed, three-bank configuration.
        frameStart();
        repeat (5) runLine(16);
        checkOutput("five_lines_cnt",       32'(b_line_cnt),  32'd5);
        checkOutput("five_lines_bank",      32'(b_bank),      32'd2);
        checkOutput("five_lines_done_bank", 32'(b_done_bank), 32'd1);
        runLine(16);
        checkOutput("sat_line_cnt", 32'(b_line_cnt), 32'd5);
        checkOutput("sat_bank",     32'(b_bank),     32'd0);

        // Short line, then a fresh line, then an overlong line.
        frameStart();
        runLine(500);
        checkOutput("short_flag", 32'(a_short_err), 32'd1);
        checkOutput("short_bank", 32'(a_bank),      32'd1);
        runLine(1285);
        checkOutput("ovf_flag",   32'(a_ovf_err),   32'd1);
        checkOutput("ovf_addr",   32'(a_addr),      32'd1279);

        // Frame restart mid-line on bank 1, then frame+line start together.
        frameStart();
        runLine(1280);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (700) applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("vsync_bank",     32'(a_bank),      32'd0);
        checkOutput("vsync_line_cnt", 32'(a_line_cnt),  32'd0);
        checkOutput("vsync_done",     32'(a_line_done), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("vs_href_addr", 32'(a_addr), 32'd2);
        checkOutput("vs_href_bank", 32'(a_bank), 32'd0);

        // Asynchronous reset in the middle of a line.
        repeat (40) applyStimulus(1'b0, 1'b1, 1'b1);
        rstn = 1'b0;
        #1;
        checkOutput("rst_addr",     32'(a_addr),     32'd0);
        checkOutput("rst_we",       32'(a_we),       32'd0);
        checkOutput("rst_line_cnt", 32'(a_line_cnt), 32'd0);
        checkOutput("rst_b_bank",   32'(b_bank),     32'd0);
        modelReset(0);
        modelReset(1);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        rstn = 1'b1;
        runLine(20);

        // Random sensor timing.
        for (int i = 0; i < 6000; i++) begin
            bit v, h, d;
            v = vsync;
            h = href;
            if ($urandom_range(0, 299) == 0) v = ~v;
            if ($urandom_range(0, 99) < 3) h = ~h;
            d = ($urandom_range(0, 3) != 0);
            applyStimulus(v, h, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
